// File: rtl/btn_debounce_pulse.sv
// btn_debounce_pulse
//   Turns a raw, bouncing push-button into a clean debounced level plus
//   single-cycle press/release pulses that advance the 4-bit counter.
//
// Parameters
//   CNT_MAX       consecutive stable cycles needed to accept a level change (>= 2)
//
// Ports
//   clk           sole clock, rising edge
//   rst           asynchronous active-high reset
//   btn_in        raw button level, asynchronous to clk
//   btn_state     registered debounced level
//   press_pulse   registered one-cycle pulse per accepted press
//   release_pulse registered one-cycle pulse per accepted release
module btn_debounce_pulse #(
    parameter int unsigned CNT_MAX = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_state,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int unsigned CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM_HI,
        HIGH,
        ARM_LO
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          sync1, btn_sync;
    logic          btn_state_n, press_n, release_n;

    // Two-flop synchronizer; only btn_sync is used downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            sync1    <= btn_in;
            btn_sync <= sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            btn_state     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            btn_state     <= btn_state_n;
            press_pulse   <= press_n;
            release_pulse <= release_n;
        end
    end

    // The counter is held at zero in the stable states, so every entry into
    // an ARM state starts from 0 and the counter can never pass CNT_LAST.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        press_n   = 1'b0;
        release_n = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (btn_sync) state_n = ARM_HI;
            end
            ARM_HI: begin
                if (!btn_sync) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = HIGH;
                    cnt_n   = '0;
                    press_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            HIGH: begin
                cnt_n = '0;
                if (!btn_sync) state_n = ARM_LO;
            end
            ARM_LO: begin
                if (btn_sync) begin
                    state_n = HIGH;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n   = IDLE;
                    cnt_n     = '0;
                    release_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        // Registered from the next state so btn_state tracks the state register.
        btn_state_n = (state_n == HIGH) || (state_n == ARM_LO);
    end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// tb_btn_debounce_pulse
//   Self-checking bench for btn_debounce_pulse with CNT_MAX=4. A run-length
//   reference model pushes the expected outputs for every clock edge into a
//   queue; they are popped and compared on the following falling edge.
module tb_btn_debounce_pulse;

    localparam int unsigned CNT_MAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_in = 1'b0;
    logic btn_state, press_pulse, release_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    btn_debounce_pulse #(.CNT_MAX(CNT_MAX)) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_in        (btn_in),
        .btn_state     (btn_state),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the debounced level flips once the synchronized input
    // has differed from it for CNT_MAX+1 consecutive samples.
    logic       m_s1 = 1'b0, m_s2 = 1'b0, m_db = 1'b0;
    logic       m_press = 1'b0, m_rel = 1'b0;
    int         m_run = 0;
    logic [2:0] exp_q[$];

    always @(posedge clk) begin
        m_press = 1'b0;
        m_rel   = 1'b0;
        if (rst) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_db = 1'b0; m_run = 0;
        end else begin
            if (m_s2 != m_db) begin
                m_run++;
                if (m_run == CNT_MAX + 1) begin
                    m_db  = ~m_db;
                    m_run = 0;
                    if (m_db) m_press = 1'b1;
                    else      m_rel   = 1'b1;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = btn_in;
        end
        exp_q.push_back({m_db, m_press, m_rel});
    end

    always @(negedge clk) begin
        logic [2:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("outputs", {29'd0, btn_state, press_pulse, release_pulse}, {29'd0, e});
            chk("pulse_excl", {31'd0, press_pulse & release_pulse}, 32'd0);
        end
    end

    // Pulse tallies and the downstream 4-bit counter.
    int         n_press = 0, n_rel = 0;
    logic [3:0] cnt4;
    always @(negedge clk) begin
        if (press_pulse)   n_press++;
        if (release_pulse) n_rel++;
    end
    always @(posedge clk or posedge rst) begin
        if (rst)              cnt4 <= 4'd0;
        else if (press_pulse) cnt4 <= cnt4 + 4'd1;
    end

    task automatic hold(input logic lvl, input int n);
        btn_in = lvl;
        repeat (n) @(negedge clk);
    endtask

    // Expects press_pulse/btn_state to rise exactly after the 7th edge.
    task automatic press_latency(input string tag);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            chk(tag, {31'd0, press_pulse}, {31'd0, (i == 7)});
        end
        chk({tag, "_state"}, {31'd0, btn_state}, 32'd1);
    endtask

    int p0, r0;

    initial begin
        // Reset state
        rst = 1'b1;
        btn_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", {29'd0, btn_state, press_pulse, release_pulse}, 32'd0);
        rst = 1'b0;
        hold(1'b0, 3);

        // Clean press with exact latency, then release
        btn_in = 1'b1;
        press_latency("press_lat");
        hold(1'b1, 6);
        hold(1'b0, 12);
        chk("release_state", {31'd0, btn_state}, 32'd0);

        // Bounce reject: 3 and 4 cycles high are too short, then a real press
        hold(1'b1, 3);
        hold(1'b0, 8);
        hold(1'b1, 4);
        hold(1'b0, 8);
        chk("bounce_state", {31'd0, btn_state}, 32'd0);
        btn_in = 1'b1;
        press_latency("bounce_press_lat");
        hold(1'b1, 4);

        // Low glitches of 2 and 4 cycles from HIGH are rejected, then release
        hold(1'b0, 2);
        hold(1'b1, 8);
        hold(1'b0, 4);
        hold(1'b1, 8);
        chk("glitch_state", {31'd0, btn_state}, 32'd1);
        hold(1'b0, 12);

        // Async reset in ARM_HI, released with the button still held
        hold(1'b1, 4);
        #2 rst = 1'b1;
        #1 chk("rst_async_armhi", {29'd0, btn_state, press_pulse, release_pulse}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        press_latency("rst_release_lat");
        hold(1'b1, 3);

        // Async reset while HIGH drops btn_state before any edge
        #2 rst = 1'b1;
        #1 chk("rst_async_high", {29'd0, btn_state, press_pulse, release_pulse}, 32'd0);
        btn_in = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        hold(1'b0, 10);

        // Counter drive: 20 clean press/release cycles
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #1;
        p0 = n_press;
        r0 = n_rel;
        for (int k = 0; k < 20; k++) begin
            hold(1'b1, 10);
            hold(1'b0, 10);
        end
        hold(1'b0, 4);
        #1;
        chk("press_count", n_press - p0, 32'd20);
        chk("release_count", n_rel - r0, 32'd20);
        chk("counter4", {28'd0, cnt4}, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Safety bound on total run time.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
